simt_reconv_stack: RTL and testbench
====================================

# simt_reconv_stack

Multi-warp SIMT divergence/reconvergence stack for one core. It holds an independent stack of `DEPTH` entries and an active thread mask for each of `NUM_WARPS` warps. For each branch or reconvergence-point command, it computes the next PC and active mask for the warp. It sits between decode/branch-resolve and the warp scheduler, which applies each response to its warp context.

## Interface
- `NUM_WARPS`, 4: warps per core; `WID = max(1, $clog2(NUM_WARPS))`
- `WARP_SIZE`, 32: lanes per warp (mask width)
- `DEPTH`, 32: stack entries per warp; `DW = $clog2(DEPTH+1)`
- `PC_WIDTH`, 32: PC width

- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  high in IDLE only
- `cmd_op`  in  2  `sstk_op_t`: INIT, BRANCH, RECONV
- `cmd_warp`  in  WID  target warp
- `cmd_mask`  in  WARP_SIZE  INIT: initial mask; BRANCH: per-lane taken predicate
- `cmd_taken_pc`  in  PC_WIDTH  BRANCH target
- `cmd_else_pc`  in  PC_WIDTH  BRANCH fall-through
- `cmd_reconv_pc`  in  PC_WIDTH  BRANCH: immediate post-dominator; RECONV: current warp PC
- `resp_valid`  out  1  one-cycle response pulse
- `resp_warp`  out  WID  warp of the response
- `resp_change`  out  1  pc/mask must be applied
- `resp_pc`  out  PC_WIDTH  next PC
- `resp_mask`  out  WARP_SIZE  next active mask
- `resp_err`  out  1  stack overflow on this command
- `overflow`  out  NUM_WARPS  sticky per-warp overflow
- `q_warp`  in  WID  query select
- `q_depth`  out  DW  combinational depth of `q_warp`
- `q_mask`  out  WARP_SIZE  combinational active mask of `q_warp`

## Operation
- Per-warp state: `mask[w]`, `depth[w]`, and entries {`reconv_pc`, `orig_mask`, `taken_mask`, `else_pc`, `phase`}.
- A command is accepted when `cmd_valid && cmd_ready`.
- **INIT:** `mask := cmd_mask`, `depth := 0`, `overflow[w] := 0`.
  - Response: `change=1`, `pc=cmd_reconv_pc`, `mask=cmd_mask`.
- **BRANCH:** `t = cmd_mask & mask[w]`, `n = mask[w] & ~cmd_mask`.
  - Both `t` and `n` zero: response `change=0`.
  - `n == 0` (uniform taken): `pc=taken_pc`, mask unchanged, no push.
  - `t == 0` (uniform not-taken): `pc=else_pc`, no push.
  - Divergent, `depth < DEPTH`: push {`reconv_pc`, `mask[w]`, `t`, `else_pc`, `phase=0`}; set `mask := t`; response `pc=taken_pc`, `mask=t`.
  - Divergent, `depth == DEPTH`: no push, state unchanged; response `change=0`, `err=1`; set `overflow[w]`.
- **RECONV:** no effect (`change=0`) if `depth == 0` or `cmd_reconv_pc != top.reconv_pc`.
  - On match with `phase=0`: set `phase := 1`, `mask := orig & ~taken`; response `pc=top.else_pc` with that mask.
  - On match with `phase=1`: pop and set `mask := orig`.
    - If the new top exists with the same `reconv_pc` and `phase=1`, enter POP_CHAIN.
    - Otherwise respond `pc=reconv_pc`, `mask=orig`.
- **FSM:**
  - IDLE: `cmd_ready=1`.
  - POP_CHAIN: `cmd_ready=0`. Each cycle, pop while the top matches the same `reconv_pc` with `phase=1`; update `mask` on every pop.
  - When the chain ends, emit a single response with `change=1` and the final mask, then return to IDLE.
  - If the new top matches with `phase=0`, the chain ends with the else-path switch on that entry (`phase := 1`, `pc=else_pc`).

## Timing
- Reset values:
  - `cmd_ready=1`.
  - `resp_valid=0`, `resp_change=0`, `resp_err=0`.
  - `resp_pc`, `resp_mask`, `resp_warp` = 0.
  - `overflow=0`; all `depth` = 0; all `mask` = 0.
- Reset asserted during POP_CHAIN aborts the chain, goes to IDLE, clears all state, and emits no response.
- Latency:
  - Responses are registered, so `resp_valid` is high in the cycle after acceptance.
  - A pop chain of k extra pops responds k cycles later. `cmd_ready` is low for exactly those k cycles.
- Throughput is one command per cycle in IDLE.
- `q_*` ports reflect state committed at the last clock edge.
- Stack index wraps never; depth is saturating-guarded by the overflow rule.

## Structure
- Add to `pkg_opengpu`:
  - `sstk_op_t`.
  - `simt_stack_entry_ext_t`, extending `simt_stack_entry_t` with `else_pc` and `phase`.
- Natural sub-module: `simt_stack_bank`, one warp's entry array plus depth pointer (push/pop/top/update-top), instantiated `NUM_WARPS` times.

## Test plan
- INIT warp 1, mask `0xFFFF_FFFF`, pc `0x100` -> response `change=1`, pc `0x100`; `q_depth=0`.
- BRANCH warp 1, pred `0x0000_FFFF`, taken `0x200`, else `0x180`, reconv `0x300` -> pc `0x200`, mask `0x0000_FFFF`, depth 1.
  - Then RECONV `0x300` -> pc `0x180`, mask `0xFFFF_0000`.
  - Then RECONV `0x300` -> pc `0x300`, mask `0xFFFF_FFFF`, depth 0.
- Uniform BRANCH with pred `0xFFFF_FFFF` -> pc = taken, no push, depth unchanged.
- Two nested divergences, both reconv `0x300`, with both else paths already run; RECONV `0x300` -> `cmd_ready` low 1 cycle, single response after 2 cycles, mask `0xFFFF_FFFF`, depth 0.
- `DEPTH=2`: third divergent BRANCH -> `resp_err=1`, `overflow[w]=1`, depth stays 2; commands to other warps are unaffected.
- Assert `rst` during POP_CHAIN -> no `resp_valid`, `cmd_ready=1`, all depths 0.

Source files
------------

// File: rtl/simt_reconv_stack_pkg.sv
// Shared types for the SIMT divergence/reconvergence stack: command opcodes,
// controller states and the stack entry layout.
package simt_reconv_stack_pkg;

  localparam int SSTK_PC_WIDTH  = 32;
  localparam int SSTK_WARP_SIZE = 32;

  typedef enum logic [1:0] {
    SSTK_INIT   = 2'd0,
    SSTK_BRANCH = 2'd1,
    SSTK_RECONV = 2'd2
  } sstk_op_t;

  typedef enum logic {
    SSTK_IDLE      = 1'b0,
    SSTK_POP_CHAIN = 1'b1
  } sstk_state_t;

  typedef struct packed {
    logic [SSTK_PC_WIDTH-1:0]  reconv_pc;
    logic [SSTK_WARP_SIZE-1:0] orig_mask;
    logic [SSTK_WARP_SIZE-1:0] taken_mask;
  } simt_stack_entry_t;

  // phase=0: taken path running; phase=1: else path running.
  typedef struct packed {
    simt_stack_entry_t        base;
    logic [SSTK_PC_WIDTH-1:0] else_pc;
    logic                     phase;
  } simt_stack_entry_ext_t;

endpackage

// File: rtl/simt_stack_bank.sv
// One warp's reconvergence stack: entry array plus depth pointer, exposing the
// top entry and the entry beneath it so a pop can look ahead in the same cycle.
module simt_stack_bank #(
  parameter int DEPTH     = 32,
  parameter int WARP_SIZE = 32,
  parameter int PC_WIDTH  = 32,
  localparam int DW = $clog2(DEPTH + 1),
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 set_top_phase,
  input  logic                 set_next_phase,
  input  logic [PC_WIDTH-1:0]  push_reconv_pc,
  input  logic [PC_WIDTH-1:0]  push_else_pc,
  input  logic [WARP_SIZE-1:0] push_orig_mask,
  input  logic [WARP_SIZE-1:0] push_taken_mask,
  output logic [DW-1:0]        depth,
  output logic [PC_WIDTH-1:0]  top_reconv_pc,
  output logic [PC_WIDTH-1:0]  top_else_pc,
  output logic [WARP_SIZE-1:0] top_orig_mask,
  output logic [WARP_SIZE-1:0] top_taken_mask,
  output logic                 top_phase,
  output logic [PC_WIDTH-1:0]  next_reconv_pc,
  output logic [PC_WIDTH-1:0]  next_else_pc,
  output logic [WARP_SIZE-1:0] next_orig_mask,
  output logic [WARP_SIZE-1:0] next_taken_mask,
  output logic                 next_phase
);

  logic [PC_WIDTH-1:0]  reconv_pc_r  [DEPTH];
  logic [PC_WIDTH-1:0]  else_pc_r    [DEPTH];
  logic [WARP_SIZE-1:0] orig_mask_r  [DEPTH];
  logic [WARP_SIZE-1:0] taken_mask_r [DEPTH];
  logic [DEPTH-1:0]     phase_r;
  logic [DW-1:0]        depth_r;
  logic [IW-1:0]        push_idx_s;
  logic [IW-1:0]        top_idx_s;
  logic [IW-1:0]        next_idx_s;

  assign push_idx_s = IW'(depth_r);
  assign top_idx_s  = IW'(depth_r - DW'(32'd1));
  assign next_idx_s = IW'(depth_r - DW'(32'd2));

  // Stack storage and depth pointer; push/pop/phase updates are mutually exclusive.
  always_ff @(posedge clk) begin
    if (rst) begin
      depth_r <= '0;
      phase_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        reconv_pc_r[i]  <= '0;
        else_pc_r[i]    <= '0;
        orig_mask_r[i]  <= '0;
        taken_mask_r[i] <= '0;
      end
    end else if (clear) begin
      depth_r <= '0;
      phase_r <= '0;
    end else if (push) begin
      reconv_pc_r[push_idx_s]  <= push_reconv_pc;
      else_pc_r[push_idx_s]    <= push_else_pc;
      orig_mask_r[push_idx_s]  <= push_orig_mask;
      taken_mask_r[push_idx_s] <= push_taken_mask;
      phase_r[push_idx_s]      <= 1'b0;
      depth_r                  <= depth_r + DW'(32'd1);
    end else if (pop) begin
      depth_r <= depth_r - DW'(32'd1);
      if (set_next_phase) begin
        phase_r[next_idx_s] <= 1'b1;
      end
    end else if (set_top_phase) begin
      phase_r[top_idx_s] <= 1'b1;
    end
  end

  assign depth           = depth_r;
  assign top_reconv_pc   = reconv_pc_r[top_idx_s];
  assign top_else_pc     = else_pc_r[top_idx_s];
  assign top_orig_mask   = orig_mask_r[top_idx_s];
  assign top_taken_mask  = taken_mask_r[top_idx_s];
  assign top_phase       = phase_r[top_idx_s];
  assign next_reconv_pc  = reconv_pc_r[next_idx_s];
  assign next_else_pc    = else_pc_r[next_idx_s];
  assign next_orig_mask  = orig_mask_r[next_idx_s];
  assign next_taken_mask = taken_mask_r[next_idx_s];
  assign next_phase      = phase_r[next_idx_s];

endmodule

// File: rtl/simt_reconv_stack.sv
// Multi-warp SIMT divergence/reconvergence controller: per-warp active mask and
// stack, one command per cycle, with a multi-cycle pop chain for nested reconvergence.
module simt_reconv_stack
  import simt_reconv_stack_pkg::*;
#(
  parameter int NUM_WARPS = 4,
  parameter int WARP_SIZE = 32,
  parameter int DEPTH     = 32,
  parameter int PC_WIDTH  = 32,
  localparam int WID = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int DW  = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  sstk_op_t             cmd_op,
  input  logic [WID-1:0]       cmd_warp,
  input  logic [WARP_SIZE-1:0] cmd_mask,
  input  logic [PC_WIDTH-1:0]  cmd_taken_pc,
  input  logic [PC_WIDTH-1:0]  cmd_else_pc,
  input  logic [PC_WIDTH-1:0]  cmd_reconv_pc,
  output logic                 resp_valid,
  output logic [WID-1:0]       resp_warp,
  output logic                 resp_change,
  output logic [PC_WIDTH-1:0]  resp_pc,
  output logic [WARP_SIZE-1:0] resp_mask,
  output logic                 resp_err,
  output logic [NUM_WARPS-1:0] overflow,
  input  logic [WID-1:0]       q_warp,
  output logic [DW-1:0]        q_depth,
  output logic [WARP_SIZE-1:0] q_mask
);

  localparam logic [DW-1:0] DEPTH_FULL = DW'(DEPTH);
  localparam logic [DW-1:0] DEPTH_TWO  = DW'(32'd2);

  sstk_state_t          state_r, state_nxt_s;
  logic                 cmd_ready_r;
  logic [WARP_SIZE-1:0] mask_r [NUM_WARPS];
  logic [WARP_SIZE-1:0] mask_nxt_s [NUM_WARPS];
  logic [NUM_WARPS-1:0] ovf_r, ovf_nxt_s;
  logic [WID-1:0]       chain_warp_r, chain_warp_nxt_s;
  logic [PC_WIDTH-1:0]  chain_pc_r, chain_pc_nxt_s;

  logic                 resp_valid_r, resp_valid_nxt_s;
  logic [WID-1:0]       resp_warp_r, resp_warp_nxt_s;
  logic                 resp_change_r, resp_change_nxt_s;
  logic                 resp_err_r, resp_err_nxt_s;
  logic [PC_WIDTH-1:0]  resp_pc_r, resp_pc_nxt_s;
  logic [WARP_SIZE-1:0] resp_mask_r, resp_mask_nxt_s;

  logic [NUM_WARPS-1:0] bk_clear_s, bk_push_s, bk_pop_s, bk_set_top_s, bk_set_next_s;
  logic [DW-1:0]        bk_depth_s       [NUM_WARPS];
  logic [PC_WIDTH-1:0]  bk_top_pc_s      [NUM_WARPS];
  logic [PC_WIDTH-1:0]  bk_top_else_s    [NUM_WARPS];
  logic [WARP_SIZE-1:0] bk_top_orig_s    [NUM_WARPS];
  logic [WARP_SIZE-1:0] bk_top_taken_s   [NUM_WARPS];
  logic                 bk_top_phase_s   [NUM_WARPS];
  logic [PC_WIDTH-1:0]  bk_next_pc_s     [NUM_WARPS];
  logic [PC_WIDTH-1:0]  bk_next_else_s   [NUM_WARPS];
  logic [WARP_SIZE-1:0] bk_next_orig_s   [NUM_WARPS];
  logic [WARP_SIZE-1:0] bk_next_taken_s  [NUM_WARPS];
  logic                 bk_next_phase_s  [NUM_WARPS];

  logic [WID-1:0]       sel_warp_s;
  logic [PC_WIDTH-1:0]  match_pc_s;
  logic [WARP_SIZE-1:0] cur_mask_s, t_s, n_s;
  logic                 top_hit_s, next_hit_s;

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_bank
    simt_stack_bank #(
      .DEPTH(DEPTH), .WARP_SIZE(WARP_SIZE), .PC_WIDTH(PC_WIDTH)
    ) u_bank (
      .clk(clk), .rst(rst), .clear(bk_clear_s[w]), .push(bk_push_s[w]), .pop(bk_pop_s[w]),
      .set_top_phase(bk_set_top_s[w]), .set_next_phase(bk_set_next_s[w]),
      .push_reconv_pc(cmd_reconv_pc), .push_else_pc(cmd_else_pc),
      .push_orig_mask(cur_mask_s), .push_taken_mask(t_s),
      .depth(bk_depth_s[w]),
      .top_reconv_pc(bk_top_pc_s[w]), .top_else_pc(bk_top_else_s[w]),
      .top_orig_mask(bk_top_orig_s[w]), .top_taken_mask(bk_top_taken_s[w]),
      .top_phase(bk_top_phase_s[w]),
      .next_reconv_pc(bk_next_pc_s[w]), .next_else_pc(bk_next_else_s[w]),
      .next_orig_mask(bk_next_orig_s[w]), .next_taken_mask(bk_next_taken_s[w]),
      .next_phase(bk_next_phase_s[w])
    );
  end

  // The pop chain owns the stack port while it runs; otherwise the command warp does.
  assign sel_warp_s = (state_r == SSTK_POP_CHAIN) ? chain_warp_r : cmd_warp;
  assign match_pc_s = (state_r == SSTK_POP_CHAIN) ? chain_pc_r : cmd_reconv_pc;
  assign cur_mask_s = mask_r[sel_warp_s];
  assign t_s        = cmd_mask & cur_mask_s;
  assign n_s        = cur_mask_s & ~cmd_mask;
  assign top_hit_s  = (bk_depth_s[sel_warp_s] != '0) && (bk_top_pc_s[sel_warp_s] == match_pc_s);
  assign next_hit_s = (bk_depth_s[sel_warp_s] >= DEPTH_TWO) && (bk_next_pc_s[sel_warp_s] == match_pc_s);

  // Next-state, stack control and response computation.
  always_comb begin
    state_nxt_s       = state_r;
    chain_warp_nxt_s  = chain_warp_r;
    chain_pc_nxt_s    = chain_pc_r;
    mask_nxt_s        = mask_r;
    ovf_nxt_s         = ovf_r;
    bk_clear_s        = '0;
    bk_push_s         = '0;
    bk_pop_s          = '0;
    bk_set_top_s      = '0;
    bk_set_next_s     = '0;
    resp_valid_nxt_s  = 1'b0;
    resp_warp_nxt_s   = resp_warp_r;
    resp_change_nxt_s = 1'b0;
    resp_err_nxt_s    = 1'b0;
    resp_pc_nxt_s     = resp_pc_r;
    resp_mask_nxt_s   = resp_mask_r;
    case (state_r)
      SSTK_IDLE: begin
        if (cmd_valid) begin
          resp_valid_nxt_s = 1'b1;
          resp_warp_nxt_s  = cmd_warp;
          resp_pc_nxt_s    = '0;
          resp_mask_nxt_s  = cur_mask_s;
          case (cmd_op)
            SSTK_INIT: begin
              mask_nxt_s[cmd_warp] = cmd_mask;
              ovf_nxt_s[cmd_warp]  = 1'b0;
              bk_clear_s[cmd_warp] = 1'b1;
              resp_change_nxt_s    = 1'b1;
              resp_pc_nxt_s        = cmd_reconv_pc;
              resp_mask_nxt_s      = cmd_mask;
            end
            SSTK_BRANCH: begin
              if ((t_s == '0) && (n_s == '0)) begin
                resp_change_nxt_s = 1'b0;
              end else if (n_s == '0) begin
                resp_change_nxt_s = 1'b1;
                resp_pc_nxt_s     = cmd_taken_pc;
              end else if (t_s == '0) begin
                resp_change_nxt_s = 1'b1;
                resp_pc_nxt_s     = cmd_else_pc;
              end else if (bk_depth_s[cmd_warp] != DEPTH_FULL) begin
                bk_push_s[cmd_warp]  = 1'b1;
                mask_nxt_s[cmd_warp] = t_s;
                resp_change_nxt_s    = 1'b1;
                resp_pc_nxt_s        = cmd_taken_pc;
                resp_mask_nxt_s      = t_s;
              end else begin
                resp_err_nxt_s      = 1'b1;
                ovf_nxt_s[cmd_warp] = 1'b1;
              end
            end
            SSTK_RECONV: begin
              if (!top_hit_s) begin
                resp_change_nxt_s = 1'b0;
              end else if (!bk_top_phase_s[cmd_warp]) begin
                bk_set_top_s[cmd_warp] = 1'b1;
                mask_nxt_s[cmd_warp]   = bk_top_orig_s[cmd_warp] & ~bk_top_taken_s[cmd_warp];
                resp_change_nxt_s      = 1'b1;
                resp_pc_nxt_s          = bk_top_else_s[cmd_warp];
                resp_mask_nxt_s        = bk_top_orig_s[cmd_warp] & ~bk_top_taken_s[cmd_warp];
              end else if (next_hit_s && bk_next_phase_s[cmd_warp]) begin
                // Response is deferred until the chain of completed entries is drained.
                bk_pop_s[cmd_warp]   = 1'b1;
                mask_nxt_s[cmd_warp] = bk_top_orig_s[cmd_warp];
                resp_valid_nxt_s     = 1'b0;
                state_nxt_s          = SSTK_POP_CHAIN;
                chain_warp_nxt_s     = cmd_warp;
                chain_pc_nxt_s       = cmd_reconv_pc;
              end else begin
                bk_pop_s[cmd_warp]   = 1'b1;
                mask_nxt_s[cmd_warp] = bk_top_orig_s[cmd_warp];
                resp_change_nxt_s    = 1'b1;
                resp_pc_nxt_s        = cmd_reconv_pc;
                resp_mask_nxt_s      = bk_top_orig_s[cmd_warp];
              end
            end
            default: begin
              resp_change_nxt_s = 1'b0;
            end
          endcase
        end else begin
          resp_valid_nxt_s = 1'b0;
        end
      end
      SSTK_POP_CHAIN: begin
        bk_pop_s[chain_warp_r]   = 1'b1;
        mask_nxt_s[chain_warp_r] = bk_top_orig_s[chain_warp_r];
        if (next_hit_s && bk_next_phase_s[chain_warp_r]) begin
          state_nxt_s = SSTK_POP_CHAIN;
        end else if (next_hit_s) begin
          bk_set_next_s[chain_warp_r] = 1'b1;
          mask_nxt_s[chain_warp_r]    = bk_next_orig_s[chain_warp_r] & ~bk_next_taken_s[chain_warp_r];
          resp_valid_nxt_s            = 1'b1;
          resp_warp_nxt_s             = chain_warp_r;
          resp_change_nxt_s           = 1'b1;
          resp_pc_nxt_s               = bk_next_else_s[chain_warp_r];
          resp_mask_nxt_s             = bk_next_orig_s[chain_warp_r] & ~bk_next_taken_s[chain_warp_r];
          state_nxt_s                 = SSTK_IDLE;
        end else begin
          resp_valid_nxt_s  = 1'b1;
          resp_warp_nxt_s   = chain_warp_r;
          resp_change_nxt_s = 1'b1;
          resp_pc_nxt_s     = chain_pc_r;
          resp_mask_nxt_s   = bk_top_orig_s[chain_warp_r];
          state_nxt_s       = SSTK_IDLE;
        end
      end
      default: begin
        state_nxt_s = SSTK_IDLE;
      end
    endcase
  end

  // State, per-warp mask/overflow and registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= SSTK_IDLE;
      cmd_ready_r   <= 1'b1;
      ovf_r         <= '0;
      chain_warp_r  <= '0;
      chain_pc_r    <= '0;
      resp_valid_r  <= 1'b0;
      resp_warp_r   <= '0;
      resp_change_r <= 1'b0;
      resp_err_r    <= 1'b0;
      resp_pc_r     <= '0;
      resp_mask_r   <= '0;
      for (int i = 0; i < NUM_WARPS; i++) begin
        mask_r[i] <= '0;
      end
    end else begin
      state_r       <= state_nxt_s;
      cmd_ready_r   <= (state_nxt_s == SSTK_IDLE);
      ovf_r         <= ovf_nxt_s;
      chain_warp_r  <= chain_warp_nxt_s;
      chain_pc_r    <= chain_pc_nxt_s;
      resp_valid_r  <= resp_valid_nxt_s;
      resp_warp_r   <= resp_warp_nxt_s;
      resp_change_r <= resp_change_nxt_s;
      resp_err_r    <= resp_err_nxt_s;
      resp_pc_r     <= resp_pc_nxt_s;
      resp_mask_r   <= resp_mask_nxt_s;
      mask_r        <= mask_nxt_s;
    end
  end

  assign cmd_ready   = cmd_ready_r;
  assign resp_valid  = resp_valid_r;
  assign resp_warp   = resp_warp_r;
  assign resp_change = resp_change_r;
  assign resp_err    = resp_err_r;
  assign resp_pc     = resp_pc_r;
  assign resp_mask   = resp_mask_r;
  assign overflow    = ovf_r;
  assign q_depth     = bk_depth_s[q_warp];
  assign q_mask      = mask_r[q_warp];

endmodule

// File: tb/tb_simt_reconv_stack.sv
// Scoreboard bench for simt_reconv_stack (DEPTH=2 so overflow is reachable):
// directed commands push expected responses, a negedge monitor pops and compares.
module tb_simt_reconv_stack;
  import simt_reconv_stack_pkg::*;

  localparam int NW  = 4;
  localparam int WS  = 32;
  localparam int DEP = 2;
  localparam int PCW = 32;
  localparam int WID = 2;
  localparam int DW  = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid;
  logic           cmd_ready;
  sstk_op_t       cmd_op;
  logic [WID-1:0] cmd_warp;
  logic [WS-1:0]  cmd_mask;
  logic [PCW-1:0] cmd_taken_pc, cmd_else_pc, cmd_reconv_pc;
  logic           resp_valid;
  logic [WID-1:0] resp_warp;
  logic           resp_change;
  logic [PCW-1:0] resp_pc;
  logic [WS-1:0]  resp_mask;
  logic           resp_err;
  logic [NW-1:0]  overflow;
  logic [WID-1:0] q_warp;
  logic [DW-1:0]  q_depth;
  logic [WS-1:0]  q_mask;

  simt_reconv_stack #(.NUM_WARPS(NW), .WARP_SIZE(WS), .DEPTH(DEP), .PC_WIDTH(PCW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_warp(cmd_warp), .cmd_mask(cmd_mask), .cmd_taken_pc(cmd_taken_pc),
    .cmd_else_pc(cmd_else_pc), .cmd_reconv_pc(cmd_reconv_pc), .resp_valid(resp_valid),
    .resp_warp(resp_warp), .resp_change(resp_change), .resp_pc(resp_pc),
    .resp_mask(resp_mask), .resp_err(resp_err), .overflow(overflow), .q_warp(q_warp),
    .q_depth(q_depth), .q_mask(q_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WID-1:0] warp;
    logic           change;
    logic           err;
    logic [PCW-1:0] pc;
    logic [WS-1:0]  mask;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;

  // Response monitor: every resp_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (resp_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL resp_unexpected warp=%0d chg=%b pc=%h mask=%h", resp_warp, resp_change, resp_pc, resp_mask);
      end else begin
        mon_e = exp_q.pop_front();
        if (resp_warp !== mon_e.warp || resp_change !== mon_e.change || resp_err !== mon_e.err ||
            (mon_e.change && (resp_pc !== mon_e.pc || resp_mask !== mon_e.mask))) begin
          n_bad++;
          $display("FAIL resp got warp=%0d chg=%b err=%b pc=%h mask=%h want warp=%0d chg=%b err=%b pc=%h mask=%h",
                   resp_warp, resp_change, resp_err, resp_pc, resp_mask,
                   mon_e.warp, mon_e.change, mon_e.err, mon_e.pc, mon_e.mask);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  task automatic qchk(input logic [WID-1:0] w, input logic [DW-1:0] xd, input logic [WS-1:0] xm);
    q_warp = w;
    #1;
    check($sformatf("q_depth_w%0d", w), 64'(q_depth), 64'(xd));
    check($sformatf("q_mask_w%0d", w), 64'(q_mask), 64'(xm));
  endtask

  task automatic issue(input sstk_op_t op, input logic [WID-1:0] w, input logic [WS-1:0] m,
                       input logic [PCW-1:0] tpc, input logic [PCW-1:0] epc, input logic [PCW-1:0] rpc,
                       input logic expect_resp, input logic chg, input logic er,
                       input logic [PCW-1:0] xpc, input logic [WS-1:0] xmask);
    int   waited;
    exp_t x;
    @(negedge clk);
    waited = 0;
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL ready_timeout op=%0d warp=%0d", op, w);
    end else begin
      cmd_valid = 1'b1; cmd_op = op; cmd_warp = w; cmd_mask = m;
      cmd_taken_pc = tpc; cmd_else_pc = epc; cmd_reconv_pc = rpc;
      if (expect_resp) begin
        x.warp = w; x.change = chg; x.err = er; x.pc = xpc; x.mask = xmask;
        exp_q.push_back(x);
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic ini(input logic [WID-1:0] w, input logic [WS-1:0] m, input logic [PCW-1:0] pc);
    issue(SSTK_INIT, w, m, 32'h0, 32'h0, pc, 1'b1, 1'b1, 1'b0, pc, m);
  endtask

  task automatic br(input logic [WID-1:0] w, input logic [WS-1:0] pred, input logic [PCW-1:0] tp,
                    input logic [PCW-1:0] ep, input logic [PCW-1:0] rp, input logic chg, input logic er,
                    input logic [PCW-1:0] xpc, input logic [WS-1:0] xm);
    issue(SSTK_BRANCH, w, pred, tp, ep, rp, 1'b1, chg, er, xpc, xm);
  endtask

  task automatic rc(input logic [WID-1:0] w, input logic [PCW-1:0] rp, input logic chg,
                    input logic [PCW-1:0] xpc, input logic [WS-1:0] xm);
    issue(SSTK_RECONV, w, 32'h0, 32'h0, 32'h0, rp, 1'b1, chg, 1'b0, xpc, xm);
  endtask

  // Builds outer divergence (else path running) with a nested divergence in its else path.
  task automatic build_nest(input logic [WID-1:0] w);
    ini(w, 32'hFFFF_FFFF, 32'h100);
    br(w, 32'h0000_FFFF, 32'h200, 32'h180, 32'h300, 1'b1, 1'b0, 32'h200, 32'h0000_FFFF);
    rc(w, 32'h300, 1'b1, 32'h180, 32'hFFFF_0000);
    br(w, 32'h00FF_0000, 32'h190, 32'h1A0, 32'h300, 1'b1, 1'b0, 32'h190, 32'h00FF_0000);
    rc(w, 32'h300, 1'b1, 32'h1A0, 32'hFF00_0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = SSTK_INIT; cmd_warp = '0; cmd_mask = '0;
    cmd_taken_pc = '0; cmd_else_pc = '0; cmd_reconv_pc = '0; q_warp = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'h1);
    check("rst_resp_valid", 64'(resp_valid), 64'h0);
    check("rst_resp_pc", 64'(resp_pc), 64'h0);
    check("rst_resp_mask", 64'(resp_mask), 64'h0);
    check("rst_overflow", 64'(overflow), 64'h0);
    for (int w = 0; w < NW; w++) qchk(WID'(w), 2'd0, 32'h0);
    rst = 1'b0;

    // Basic divergence / reconvergence on warp 1.
    ini(1, 32'hFFFF_FFFF, 32'h100);
    qchk(1, 2'd0, 32'hFFFF_FFFF);
    br(1, 32'h0000_FFFF, 32'h200, 32'h180, 32'h300, 1'b1, 1'b0, 32'h200, 32'h0000_FFFF);
    qchk(1, 2'd1, 32'h0000_FFFF);
    rc(1, 32'h300, 1'b1, 32'h180, 32'hFFFF_0000);
    qchk(1, 2'd1, 32'hFFFF_0000);
    rc(1, 32'h300, 1'b1, 32'h300, 32'hFFFF_FFFF);
    qchk(1, 2'd0, 32'hFFFF_FFFF);

    // Uniform branches and a reconvergence on an empty stack.
    br(1, 32'hFFFF_FFFF, 32'h400, 32'h404, 32'h500, 1'b1, 1'b0, 32'h400, 32'hFFFF_FFFF);
    qchk(1, 2'd0, 32'hFFFF_FFFF);
    br(1, 32'h0000_0000, 32'h410, 32'h414, 32'h500, 1'b1, 1'b0, 32'h414, 32'hFFFF_FFFF);
    rc(1, 32'h300, 1'b0, 32'h0, 32'h0);

    // Fill the two-entry stack, mismatched reconv, then overflow.
    br(1, 32'h0000_FFFF, 32'h200, 32'h180, 32'h300, 1'b1, 1'b0, 32'h200, 32'h0000_FFFF);
    br(1, 32'h0000_00FF, 32'h210, 32'h208, 32'h300, 1'b1, 1'b0, 32'h210, 32'h0000_00FF);
    rc(1, 32'h999, 1'b0, 32'h0, 32'h0);
    br(1, 32'h0000_000F, 32'h220, 32'h218, 32'h300, 1'b0, 1'b1, 32'h0, 32'h0);
    qchk(1, 2'd2, 32'h0000_00FF);
    check("overflow_w1", 64'(overflow), 64'h2);

    // Other warp unaffected by warp 1 overflow.
    ini(0, 32'h0000_000F, 32'h40);
    br(0, 32'h0000_0003, 32'h50, 32'h54, 32'h60, 1'b1, 1'b0, 32'h50, 32'h0000_0003);
    qchk(0, 2'd1, 32'h0000_0003);
    check("overflow_w0_clean", 64'(overflow), 64'h2);
    ini(1, 32'hFFFF_FFFF, 32'h100);
    check("overflow_init_clears", 64'(overflow), 64'h0);
    qchk(1, 2'd0, 32'hFFFF_FFFF);

    // Nested pop chain on warp 2: one extra pop, response two cycles after acceptance.
    build_nest(2);
    qchk(2, 2'd2, 32'hFF00_0000);
    rc(2, 32'h300, 1'b1, 32'h300, 32'hFFFF_FFFF);
    check("chain_ready_low", 64'(cmd_ready), 64'h0);
    check("chain_no_early_resp", 64'(resp_valid), 64'h0);
    @(posedge clk);
    #1;
    check("chain_ready_back", 64'(cmd_ready), 64'h1);
    check("chain_resp_valid", 64'(resp_valid), 64'h1);
    qchk(2, 2'd0, 32'hFFFF_FFFF);

    // Reset during a pop chain on warp 3 aborts it silently.
    build_nest(3);
    issue(SSTK_RECONV, 3, 32'h0, 32'h0, 32'h0, 32'h300, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("rstchain_ready_low", 64'(cmd_ready), 64'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rstchain_no_resp", 64'(resp_valid), 64'h0);
    check("rstchain_ready", 64'(cmd_ready), 64'h1);
    check("rstchain_overflow", 64'(overflow), 64'h0);
    for (int w = 0; w < NW; w++) qchk(WID'(w), 2'd0, 32'h0);
    rst = 1'b0;

    // Empty active mask: branch has no effect.
    br(3, 32'hFFFF_FFFF, 32'h700, 32'h704, 32'h800, 1'b0, 1'b0, 32'h0, 32'h0);
    qchk(3, 2'd0, 32'h0);

    repeat (4) @(posedge clk);
    #1;
    check("pending_responses", 64'(exp_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
